// File: rtl/sync_debounce.sv
// Raw-input conditioner: synchroniser chain, counter debounce, edge strobes.
// All state lives in clk; rst clears everything asynchronously.
module sync_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] DB_LIM =
    CNT_W'(DB_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_d;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   q_d;
  logic                   rise_d;
  logic                   fall_d;
  logic                   commit;

  // Plain flop chain, nothing between stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      q    <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      cnt  <= cnt_d;
      q    <= q_d;
      rise <= rise_d;
      fall <= fall_d;
    end
  end

  assign cnt_inc = cnt + 1'b1;

  // A change commits only if s still differs on the completing edge.
  always_comb begin
    commit = 1'b0;
    cnt_d  = '0;
    q_d    = q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s != q) begin
      if (cnt_inc == DB_LIM) begin
        commit = 1'b1;
        q_d    = s;
      end else begin
        cnt_d = cnt_inc;
      end
    end
    rise_d = commit & s & ~q;
    fall_d = commit & ~s & q;
  end

  always_comb begin
    busy = (cnt != '0);
  end

endmodule

// File: doc/sync_debounce.md
Name: sync_debounce

Overview:
- Conditions one raw asynchronous input, such as a switch, button or external strobe, so it can drive the d input of downstream flip-flop stages.
- Stages: a multi-flop synchroniser, then a counter-based debounce filter, then edge detection.
- Outputs: a clean registered level plus single-cycle rise and fall strobes, all in the clk domain.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops; legal range ≥2.
DB_CYCLES, 4, consecutive differing clk edges required before the output level changes; legal range 1 .. 2^CNT_W-1.
CNT_W, 8, width of the debounce counter.

Ports:
clk  input  1  single clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
d_in  input  1  raw asynchronous input; no timing relation to clk.
q  output  1  debounced, registered level.
rise  output  1  one-cycle pulse when q goes 0->1.
fall  output  1  one-cycle pulse when q goes 1->0.
busy  output  1  high while the debounce counter is nonzero, i.e. a change is pending.

Behaviour:
- Reset is asynchronous and active-high. While rst=1, every flop clears immediately, independent of clk:
  - synchroniser chain = 0, counter = 0, q = 0, rise = 0, fall = 0, busy = 0.
- Reset mid-count discards the pending change. After release, filtering restarts from q=0.
- Synchroniser:
  - d_in passes through SYNC_STAGES flops in series; the last flop's output is s.
  - No logic sits between the chain flops.
  - s equals d_in delayed by SYNC_STAGES edges, provided setup is met.
- Filter state is implied by the counter: STABLE (cnt=0) and PENDING (cnt≠0). At each posedge:
  - s==q: cnt<=0. This aborts any pending change, so glitches shorter than DB_CYCLES are rejected.
  - s!=q and cnt+1<DB_CYCLES: cnt<=cnt+1.
  - s!=q and cnt+1==DB_CYCLES: q<=s, cnt<=0.
- Width and arithmetic rules:
  - The counter never wraps; it clears on reaching DB_CYCLES.
  - The compare is done at CNT_W bits.
  - DB_CYCLES=1 means q follows s with one edge of delay.
- rise and fall:
  - rise and fall are registered and asserted on the same edge that updates q: rise<=(s & ~q), fall<=(~s & q), both gated by the commit condition.
  - Each stays high exactly one cycle.
  - rise and fall are never high together.
- busy = (cnt != 0). It is combinational from the counter register only.
- Latency from a d_in step (setup met before edge 1) to q changing:
  - edge SYNC_STAGES+DB_CYCLES; with defaults, edge 6.
  - rise/fall are high from edge 6 until edge 7.
- Simultaneous events: if s returns to q on the same edge the count would have completed, no commit occurs, because commit requires s!=q on that edge.
- The output level is held indefinitely while s==q.

Test Plan:
- Reset with d_in=1: assert rst, release. Check q=0 during reset. Check q=1 at edge 6 after release, rise=1 for one cycle, fall=0 throughout.
- Clean step (defaults), d_in 0->1 before edge 1:
  - busy=1 after edges 3-5.
  - q=1 and rise=1 after edge 6; rise=0 after edge 7.
  - Then drive d_in 1->0: q=0 and fall=1 at the 6th edge.
- Glitch rejection: d_in high for 3 cycles, then low. Check busy pulses high, q stays 0, no rise. Repeat with 4 cycles high: q=1 at edge 6, rise pulses.
- Bounce: d_in toggles 1,0,1,0,1 every cycle, then holds 1. Check q changes only after 4 consecutive differing edges of s, with exactly one rise pulse total.
- Reset mid-count: after d_in 0->1, assert rst asynchronously between edges 4 and 5. Check cnt, busy and q clear immediately. After release with d_in=1, q=1 at the 6th edge.
- DB_CYCLES=1, SYNC_STAGES=3: d_in step gives q change at edge 4. Check a 1-cycle d_in pulse produces a 1-cycle rise followed by fall.
